// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational from registered state; resolves update the table on the clock edge.
module branch_target_predictor #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] fetch_pc,
  output logic [15:0] predict_target,
  output logic        speculatively_taken,
  output logic        branch_predictor_taken_and_btb_valid,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  input  logic        res_require_reset,
  output logic        incorrect_target,
  output logic [15:0] mispredict_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 15 - IW;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [TW-1:0]      tag_d    [ENTRIES];
  logic [15:0]        target_q [ENTRIES];
  logic [15:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [15:0]        count_q, count_d;

  logic [IW-1:0] fetch_idx, res_idx;
  logic [TW-1:0] fetch_tag, res_tag;
  logic          fetch_hit, res_hit;
  logic          unused_pc_lsb;

  // Bit 0 of a PC is always zero for word-aligned instructions.
  assign unused_pc_lsb = fetch_pc[0] ^ res_pc[0];

  assign fetch_idx = fetch_pc[IW:1];
  assign fetch_tag = fetch_pc[15:IW+1];
  assign res_idx   = res_pc[IW:1];
  assign res_tag   = res_pc[15:IW+1];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign res_hit   = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  // Target is driven even on a miss; consumers qualify it with speculatively_taken.
  assign predict_target                       = target_q[fetch_idx];
  assign speculatively_taken                  = fetch_hit && ctr_q[fetch_idx][1];
  assign branch_predictor_taken_and_btb_valid = speculatively_taken;
  assign incorrect_target = res_valid && res_hit && res_taken &&
                            (target_q[res_idx] != res_target);
  assign mispredict_count = count_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (res_valid) begin
      if (res_taken) begin
        if (res_hit) begin
          if (ctr_q[res_idx] != 2'b11) begin
            ctr_d[res_idx] = ctr_q[res_idx] + 2'b01;
          end
          target_d[res_idx] = res_target;
        end else begin
          valid_d[res_idx]  = 1'b1;
          tag_d[res_idx]    = res_tag;
          target_d[res_idx] = res_target;
          ctr_d[res_idx]    = 2'b10;
        end
      end else if (res_hit && (ctr_q[res_idx] != 2'b00)) begin
        ctr_d[res_idx] = ctr_q[res_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (res_valid && res_require_reset && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed checks of branch_target_predictor against a table model.
module tb_branch_target_predictor;

  localparam int ENTRIES = 8;
  localparam int IW = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [15:0] predict_target;
  logic        speculatively_taken;
  logic        branch_predictor_taken_and_btb_valid;
  logic        res_valid = 1'b0;
  logic [15:0] res_pc = '0;
  logic        res_taken = 1'b0;
  logic [15:0] res_target = '0;
  logic        res_require_reset = 1'b0;
  logic        incorrect_target;
  logic [15:0] mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
    .predict_target(predict_target), .speculatively_taken(speculatively_taken),
    .branch_predictor_taken_and_btb_valid(branch_predictor_taken_and_btb_valid),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_require_reset(res_require_reset),
    .incorrect_target(incorrect_target), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference table: the rules applied directly with plain arithmetic.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [15:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_cnt;

  function automatic int m_idx(input logic [15:0] pc);
    return (int'(pc) >> 1) % ENTRIES;
  endfunction
  function automatic int m_tagf(input logic [15:0] pc);
    return int'(pc) >> (IW + 1);
  endfunction
  function automatic bit m_hit(input logic [15:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagf(pc));
  endfunction
  function automatic bit exp_spec();
    return m_hit(fetch_pc) && (m_ctr[m_idx(fetch_pc)] >= 2);
  endfunction
  function automatic logic [15:0] exp_tgt();
    return m_tgt[m_idx(fetch_pc)];
  endfunction
  function automatic bit exp_inc();
    return res_valid && res_taken && m_hit(res_pc) && (m_tgt[m_idx(res_pc)] != res_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endtask

  task automatic apply(input logic [15:0] f, input logic rv, input logic [15:0] rp,
                       input logic rt, input logic [15:0] rtg, input logic rr);
    @(negedge clk);
    fetch_pc = f; res_valid = rv; res_pc = rp; res_taken = rt;
    res_target = rtg; res_require_reset = rr;
    #1;
  endtask

  // Advance one edge and apply the same resolve to the model.
  task automatic tick();
    int i;
    @(posedge clk);
    if (res_valid && reset_n) begin
      i = m_idx(res_pc);
      if (res_taken) begin
        if (m_hit(res_pc)) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = res_target;
        end else begin
          m_valid[i] = 1; m_tag[i] = m_tagf(res_pc); m_tgt[i] = res_target; m_ctr[i] = 2;
        end
      end else if (m_hit(res_pc) && m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
      if (res_require_reset && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    vectors++;
    if (speculatively_taken !== 1'b0 || branch_predictor_taken_and_btb_valid !== 1'b0 ||
        predict_target !== 16'h0 || incorrect_target !== 1'b0 || mispredict_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: spec=%b bptv=%b tgt=%h inc=%b cnt=%h, required all zero",
               speculatively_taken, branch_predictor_taken_and_btb_valid, predict_target,
               incorrect_target, mispredict_count);
    end
    // Resolves while held in reset must not take effect.
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b1);
    @(posedge clk);
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b1);
    @(posedge clk);
    apply(16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (speculatively_taken !== 1'b0 || predict_target !== 16'h0 || mispredict_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_hold: spec=%b tgt=%h cnt=%h, required 0/0000/0000",
               speculatively_taken, predict_target, mispredict_count);
    end
  endtask

  task automatic test_basic();
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b0 || predict_target !== 16'h0 || incorrect_target !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_before: spec=%b tgt=%h inc=%b, required 0/0000/0",
               speculatively_taken, predict_target, incorrect_target);
    end
    tick();
    apply(16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b1 || branch_predictor_taken_and_btb_valid !== 1'b1 ||
        predict_target !== 16'h0100) begin
      miscompares++;
      $display("FAIL basic_after: spec=%b bptv=%b tgt=%h, required 1/1/0100",
               speculatively_taken, branch_predictor_taken_and_btb_valid, predict_target);
    end
    tick();
  endtask

  task automatic test_counter();
    logic [8:0] taken_seq;
    logic [8:0] spec_seq;
    taken_seq = 9'b001111000;
    spec_seq  = 9'b100011110;
    for (int k = 0; k < 9; k++) begin
      apply(16'h0040, (k < 8), 16'h0040, taken_seq[8-k], 16'h0100, 1'b0);
      vectors++;
      if (speculatively_taken !== spec_seq[8-k] || speculatively_taken !== exp_spec()) begin
        miscompares++;
        $display("FAIL counter_step%0d: spec=%b, required %b", k, speculatively_taken, spec_seq[8-k]);
      end
      tick();
    end
  endtask

  task automatic test_incorrect_target();
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0);
    tick();
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0200, 1'b0);
    vectors++;
    if (incorrect_target !== 1'b1) begin
      miscompares++;
      $display("FAIL incorrect_target_flag: got %b, required 1", incorrect_target);
    end
    tick();
    apply(16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0200, 1'b0);
    vectors++;
    if (predict_target !== 16'h0200 || incorrect_target !== 1'b0) begin
      miscompares++;
      $display("FAIL incorrect_target_update: tgt=%h inc=%b, required 0200/0",
               predict_target, incorrect_target);
    end
    tick();
  endtask

  task automatic test_alias();
    apply(16'h0050, 1'b1, 16'h0050, 1'b1, 16'h0300, 1'b0);
    tick();
    apply(16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL alias_old_miss: spec=%b, required 0", speculatively_taken);
    end
    tick();
    apply(16'h0050, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b1 || predict_target !== 16'h0300) begin
      miscompares++;
      $display("FAIL alias_new_hit: spec=%b tgt=%h, required 1/0300", speculatively_taken, predict_target);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    apply(16'h00A2, 1'b1, 16'h00A2, 1'b1, 16'h0444, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b0 || predict_target !== 16'h0) begin
      miscompares++;
      $display("FAIL b2b_same_cycle: spec=%b tgt=%h, required 0/0000", speculatively_taken, predict_target);
    end
    tick();
    apply(16'h00A2, 1'b1, 16'h00A2, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b1 || predict_target !== 16'h0444) begin
      miscompares++;
      $display("FAIL b2b_next_cycle: spec=%b tgt=%h, required 1/0444", speculatively_taken, predict_target);
    end
    tick();
    apply(16'h00A2, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    vectors++;
    if (speculatively_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_decrement: spec=%b, required 0", speculatively_taken);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] f, rp;
    for (int n = 0; n < 1500; n++) begin
      f  = 16'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1));
      rp = 16'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1));
      apply(f, ($urandom_range(0, 9) < 7), rp, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 3) << 8), 1'($urandom_range(0, 1)));
      vectors++;
      if (speculatively_taken !== exp_spec() || branch_predictor_taken_and_btb_valid !== exp_spec() ||
          predict_target !== exp_tgt() || incorrect_target !== exp_inc() ||
          mispredict_count !== 16'(m_cnt)) begin
        miscompares++;
        $display("FAIL random_%0d: spec=%b bptv=%b tgt=%h inc=%b cnt=%h, required %b/%b/%h/%b/%h",
                 n, speculatively_taken, branch_predictor_taken_and_btb_valid, predict_target,
                 incorrect_target, mispredict_count, exp_spec(), exp_spec(), exp_tgt(),
                 exp_inc(), 16'(m_cnt));
      end
      tick();
    end
  endtask

  task automatic test_mispredict_count();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      apply(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0, 1'b1);
      if (i == 1000 || i == 65535) begin
        vectors++;
        if (mispredict_count !== 16'(i)) begin
          miscompares++;
          $display("FAIL count_at_%0d: got %h, required %h", i, mispredict_count, 16'(i));
        end
      end
      tick();
    end
    apply(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0, 1'b1);
    vectors++;
    if (mispredict_count !== 16'hFFFF || mispredict_count !== 16'(m_cnt)) begin
      miscompares++;
      $display("FAIL count_saturate: got %h, required FFFF", mispredict_count);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (mispredict_count !== 16'h0) begin
      miscompares++;
      $display("FAIL count_async_clear: got %h, required 0000", mispredict_count);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_counter();
    test_incorrect_target();
    test_alias();
    test_back_to_back();
    test_random();
    test_mispredict_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
